// File: rtl/prog_ram.sv
// prog_ram: writable program/data memory for the SAP-class CPU.
// Run mode serves the CPU bus (active-low CE_bar read, WE_bar write).
// Program mode hands the memory to a valid/ready byte loader that
// auto-increments its own address. Reset optionally zero-fills every word.
// Optional feature: define PROG_RAM_PARITY_EN to store an even-parity bit
// per word and report mismatches on reads through parity_err.
module prog_ram #(
  parameter int WORD_SIZE      = 8,
  parameter int ADDRESS_SIZE   = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_mode,
  input  logic                    CE_bar,
  input  logic                    WE_bar,
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0]    wdata,
  output logic [WORD_SIZE-1:0]    rdata,
  input  logic                    ld_valid,
  input  logic [WORD_SIZE-1:0]    ld_data,
  output logic                    ld_ready,
  output logic                    ld_done,
  output logic                    busy,
  input  logic                    parity_inject,
  output logic                    parity_err
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(DEPTH - 1);
  localparam logic [WORD_SIZE-1:0]    ALL_ONES  = '1;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD
  } state_t;

  state_t state_q, state_d;

  logic [ADDRESS_SIZE-1:0] clr_addr_q, clr_addr_d;
  logic [ADDRESS_SIZE-1:0] ld_addr_q, ld_addr_d;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic                    ld_ready_q, ld_ready_d;
  logic                    ld_done_q, ld_done_d;
  logic                    busy_q, busy_d;

  // Storage array; contents are not reset, the CLEAR sequence initialises them.
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  // Single shared write port, steered by whichever agent owns the memory.
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_waddr;
  logic [WORD_SIZE-1:0]    mem_wdata;
  logic                    mem_winject;
  logic                    read_en;
  logic                    ld_xfer;

  // Next-state logic: picks the memory owner, write port source and counters.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ld_addr_d   = ld_addr_q;
    ld_done_d   = 1'b0;
    read_en     = 1'b0;
    ld_xfer     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = wdata;
    mem_winject = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        read_en = ~CE_bar;
        if (!WE_bar) begin
          mem_we      = 1'b1;
          mem_winject = parity_inject;
        end
        if (prog_mode) begin
          state_d   = ST_LOAD;
          ld_addr_d = '0;
        end
      end

      ST_LOAD: begin
        ld_xfer = ld_valid & ld_ready_q;
        if (ld_xfer) begin
          mem_we      = 1'b1;
          mem_waddr   = ld_addr_q;
          mem_wdata   = ld_data;
          mem_winject = parity_inject;
          ld_addr_d   = ld_addr_q + 1'b1;
          ld_done_d   = (ld_addr_q == LAST_ADDR);
        end
        if (!prog_mode) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d == ST_CLEAR);
    ld_ready_d = (state_d == ST_LOAD);
  end

  // Read data mux: only a run-mode read returns memory, everything else floats high.
  always_comb begin
    rdata_d = ALL_ONES;
    if (read_en) begin
      rdata_d = mem_q[addr];
    end
  end

  // Control registers; reset aborts any fill or load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_IDLE;
      end
      clr_addr_q <= '0;
      ld_addr_q  <= '0;
      rdata_q    <= ALL_ONES;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      busy_q     <= CLEAR_ON_RESET;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ld_addr_q  <= ld_addr_d;
      rdata_q    <= rdata_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      busy_q     <= busy_d;
    end
  end

  // Memory write port; the read above sees the old word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef PROG_RAM_PARITY_EN
  logic mem_par_q [DEPTH];
  logic parity_err_q, parity_err_d;

  // Parity storage written alongside every data write, optionally corrupted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_par_q[mem_waddr] <= (^mem_wdata) ^ mem_winject;
    end
  end

  // Mismatch check only on run-mode reads, aligned with rdata.
  always_comb begin
    parity_err_d = 1'b0;
    if (read_en) begin
      parity_err_d = (mem_par_q[addr] != (^mem_q[addr]));
    end
  end

  // Parity error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_inject ^ mem_winject;
  assign parity_err    = 1'b0;
`endif

  assign rdata    = rdata_q;
  assign ld_ready = ld_ready_q;
  assign ld_done  = ld_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: directed bench for prog_ram with a behavioural reference model.
module tb_prog_ram;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_mode;
  logic       CE_bar;
  logic       WE_bar;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;
  logic       parity_inject;
  logic       parity_err;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  bit cmp_en    = 1'b0;

  prog_ram dut (
    .clk          (clk),
    .rst          (rst),
    .prog_mode    (prog_mode),
    .CE_bar       (CE_bar),
    .WE_bar       (WE_bar),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_done      (ld_done),
    .busy         (busy),
    .parity_inject(parity_inject),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  typedef enum {M_FILL, M_RUN, M_LOAD} mode_t;

  mode_t      model_mode = M_FILL;
  logic [7:0] model_mem [DEPTH];
  logic       model_bad [DEPTH];
  int         fill_idx   = 0;
  int         load_idx   = 0;
  logic [7:0] exp_rdata  = 8'hFF;
  logic       exp_busy   = 1'b1;
  logic       exp_ready  = 1'b0;
  logic       exp_done   = 1'b0;
  logic       exp_perr   = 1'b0;

  // One comparison: count it, report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the consuming edge pass, return just after it.
  task automatic applyStimulus(input logic p, input logic ce, input logic we,
                               input logic [3:0] a, input logic [7:0] wd,
                               input logic lv, input logic [7:0] ld,
                               input logic inj);
    prog_mode     = p;
    CE_bar        = ce;
    WE_bar        = we;
    addr          = a;
    wdata         = wd;
    ld_valid      = lv;
    ld_data       = ld;
    parity_inject = inj;
    @(posedge clk);
    #1;
  endtask

  // Count cycles busy stays high after reset release, bounded.
  task automatic waitFill(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: memory as an array, mode as a simple enum of who owns it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_mode = M_FILL;
      fill_idx   = 0;
      load_idx   = 0;
      exp_rdata  = 8'hFF;
      exp_busy   = 1'b1;
      exp_ready  = 1'b0;
      exp_done   = 1'b0;
      exp_perr   = 1'b0;
    end else begin
      exp_done = 1'b0;
      exp_perr = 1'b0;
      exp_rdata = 8'hFF;
      case (model_mode)
        M_FILL: begin
          model_mem[fill_idx] = 8'h00;
          model_bad[fill_idx] = 1'b0;
          if (fill_idx == DEPTH - 1) begin
            model_mode = M_RUN;
            exp_busy   = 1'b0;
          end
          fill_idx = (fill_idx + 1) % DEPTH;
        end
        M_RUN: begin
          if (!CE_bar) begin
            exp_rdata = model_mem[addr];
`ifdef PROG_RAM_PARITY_EN
            exp_perr = model_bad[addr];
`endif
          end
          if (!WE_bar) begin
            model_mem[addr] = wdata;
            model_bad[addr] = parity_inject;
          end
          if (prog_mode) begin
            model_mode = M_LOAD;
            load_idx   = 0;
            exp_ready  = 1'b1;
          end
        end
        default: begin
          if (ld_valid) begin
            model_mem[load_idx] = ld_data;
            model_bad[load_idx] = parity_inject;
            exp_done = (load_idx == DEPTH - 1);
            load_idx = (load_idx + 1) % DEPTH;
          end
          if (!prog_mode) begin
            model_mode = M_RUN;
            exp_ready  = 1'b0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("rdata", rdata, exp_rdata);
      checkOutput("busy", busy, exp_busy);
      checkOutput("ld_ready", ld_ready, exp_ready);
      checkOutput("ld_done", ld_done, exp_done);
      checkOutput("parity_err", parity_err, exp_perr);
      if (ld_done === 1'b1) done_seen++;
    end
  end

  logic [3:0] re_addr [5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd9};
  logic [7:0] re_val  [5] = '{8'h60, 8'h51, 8'h55, 8'h16, 8'h19};

  // Directed sequence with hand-computed literal expectations.
  initial begin
    int cnt;
    logic exp_inj_err;
`ifdef PROG_RAM_PARITY_EN
    exp_inj_err = 1'b1;
`else
    exp_inj_err = 1'b0;
`endif
    rst = 1'b1;
    prog_mode = 1'b0; CE_bar = 1'b1; WE_bar = 1'b1; addr = '0; wdata = '0;
    ld_valid = 1'b0; ld_data = '0; parity_inject = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_rdata", rdata, 8'hFF);
    checkOutput("rst_ready", ld_ready, 0);
    checkOutput("rst_done", ld_done, 0);
    checkOutput("rst_perr", parity_err, 0);

    // Hostile inputs during the fill must all be ignored.
    prog_mode = 1'b1; CE_bar = 1'b0; WE_bar = 1'b0; addr = 4'd5; wdata = 8'h77;
    ld_valid = 1'b1; ld_data = 8'h99;
    rst = 1'b0;
    cmp_en = 1'b1;
    waitFill(cnt);
    checkOutput("fill_cycles", cnt, 16);
    prog_mode = 1'b0; CE_bar = 1'b1; WE_bar = 1'b1; ld_valid = 1'b0;
    checkOutput("fill_no_load", ld_ready, 0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("clr_rd", rdata, 8'h00);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("ce_off_rd", rdata, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("wr_rd_a5", rdata, 8'hA5);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd7, 8'h11, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 8'h3C, 1'b0, 8'h00, 1'b0);
    checkOutput("rbw_old", rdata, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd7, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("rbw_new", rdata, 8'h3C);

    done_seen = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("ld_ready_up", ld_ready, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 3 == 1) applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'(16 + i), 1'b0);
    end
    checkOutput("ld_done_pulse", ld_done, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("ld_done_once", done_seen, 1);
    checkOutput("ld_ready_down", ld_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("load_rd", rdata, 32'(16 + i));
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd9, 8'hEE, 1'b1, 8'(80 + i), 1'b0);
      checkOutput("load_rd_forced", rdata, 8'hFF);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'h55, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'h60, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, re_addr[i], 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("reload_rd", rdata, re_val[i]);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 8'h42, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("par_inj_err", parity_err, 32'(exp_inj_err));
    checkOutput("par_inj_data", rdata, 8'h42);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 8'h43, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("par_ok_err", parity_err, 0);
    checkOutput("par_ok_data", rdata, 8'h43);

    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 8'hBB, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midload_rst_busy", busy, 1);
    checkOutput("midload_rst_ready", ld_ready, 0);
    checkOutput("midload_rst_rdata", rdata, 8'hFF);
    prog_mode = 1'b0; ld_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitFill(cnt);
    checkOutput("refill_cycles", cnt, 16);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_rd0", rdata, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("post_rst_rd1", rdata, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
